// File: rtl/fp_rsp_collector.sv
// Merges FP-core responses through per-input 2-entry skid FIFOs into one registered, round-robin writeback port.
// Latency: push at edge T is visible on valid_out after edge T+1. Backpressure: ready_in depends only on FIFO fill.
module fp_rsp_collector #(
    parameter int NUM_REQS = 2,
    parameter int LANES    = 1,
    parameter int TAGW     = 1,
    localparam int DW      = LANES * 32,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQS-1:0]      valid_in,
    output logic [NUM_REQS-1:0]      ready_in,
    input  logic [NUM_REQS*TAGW-1:0] tag_in,
    input  logic [NUM_REQS*DW-1:0]   data_in,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [TAGW-1:0]          tag_out,
    output logic [DW-1:0]            data_out,
    output logic [SELW-1:0]          sel_out
);

    logic [DW-1:0]       dmem [NUM_REQS][2];
    logic [TAGW-1:0]     tmem [NUM_REQS][2];
    logic [NUM_REQS-1:0] rd_ptr;
    logic [NUM_REQS-1:0] wr_ptr;
    logic [1:0]          cnt [NUM_REQS];
    logic [SELW-1:0]     rr_ptr;
    logic [SELW-1:0]     gnt_idx;
    logic                gnt_vld;
    logic                load;
    logic [NUM_REQS-1:0] push;
    logic [NUM_REQS-1:0] pop;
    logic [DW-1:0]       head_dat;
    logic [TAGW-1:0]     head_tag;

    assign load = ~valid_out | ready_out;
    assign push = valid_in & ready_in;

    // Ready comes from the fill counts only, so ready_out never reaches ready_in combinationally.
    always_comb begin
        ready_in = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            ready_in[i] = (cnt[i] != 2'd2) & ~reset;
        end
    end

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) begin
                idx = idx - NUM_REQS;
            end
            if (!gnt_vld && cnt[idx] != 2'd0) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

    always_comb begin
        head_dat = '0;
        head_tag = '0;
        pop      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt_idx == SELW'(i)) begin
                head_dat = dmem[i][rd_ptr[i]];
                head_tag = tmem[i][rd_ptr[i]];
                pop[i]   = load & gnt_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (push[i]) begin
                dmem[i][wr_ptr[i]] <= data_in[i*DW +: DW];
                tmem[i][wr_ptr[i]] <= tag_in[i*TAGW +: TAGW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 2'd1;
                    2'b01:   cnt[i] <= cnt[i] - 2'd1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // A load with nothing granted only clears valid; stale payload stays put.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            tag_out   <= '0;
            data_out  <= '0;
            sel_out   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            valid_out <= gnt_vld;
            if (gnt_vld) begin
                data_out <= head_dat;
                tag_out  <= head_tag;
                sel_out  <= gnt_idx;
                rr_ptr   <= (gnt_idx == SELW'(NUM_REQS - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

endmodule
